// File: rtl/logic_unit_arbiter.sv
// logic_unit_arbiter: round-robin sequencer that shares one combinational
// bitwise logic unit between two requesters. Each operation takes
// IDLE -> EXEC -> RESP, and the response is held until it is accepted.
module logic_unit_arbiter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [1:0]       i_req,
    input  logic [1:0]       i_op0,
    input  logic [WIDTH-1:0] i_a0,
    input  logic [WIDTH-1:0] i_b0,
    input  logic [1:0]       i_op1,
    input  logic [WIDTH-1:0] i_a1,
    input  logic [WIDTH-1:0] i_b1,
    output logic [1:0]       o_gnt,
    output logic [WIDTH-1:0] o_lu_a,
    output logic [WIDTH-1:0] o_lu_b,
    output logic [1:0]       o_lu_op,
    input  logic [WIDTH-1:0] i_lu_out,
    output logic             o_rsp_valid,
    output logic             o_rsp_id,
    output logic [WIDTH-1:0] o_rsp_data,
    input  logic             i_rsp_ready,
    output logic             o_busy,
    output logic [CNT_W-1:0] o_op_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic             r_last;      // requester granted last; loses the next tie
    logic             r_win;       // owner of the operation in flight
    logic [1:0]       r_gnt;
    logic [WIDTH-1:0] r_lu_a;
    logic [WIDTH-1:0] r_lu_b;
    logic [1:0]       r_lu_op;
    logic             r_rsp_valid;
    logic [WIDTH-1:0] r_rsp_data;
    logic [CNT_W-1:0] r_cnt;

    logic             w_win;
    logic             w_load;
    logic             w_capture;
    logic             w_accept;

    // Winner select: a lone requester wins, a tie goes to the one not granted last.
    always_comb begin
        w_win = (i_req == 2'b11) ? ~r_last : i_req[1];
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    // Next-state logic: EXEC is a fixed single cycle, RESP waits for ready.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (i_req != 2'b00) w_next = S_EXEC;
            S_EXEC:  w_next = S_RESP;
            S_RESP:  if (i_rsp_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Output/control decode from the current state.
    always_comb begin
        w_load    = (r_state == S_IDLE) && (i_req != 2'b00);
        w_capture = (r_state == S_EXEC);
        w_accept  = (r_state == S_RESP) && i_rsp_ready;
        o_busy    = (r_state != S_IDLE);
    end

    // Launch: latch the winner's operands, remember it, pulse its grant.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_gnt   <= 2'b00;
            r_lu_a  <= '0;
            r_lu_b  <= '0;
            r_lu_op <= 2'b00;
            r_win   <= 1'b0;
        end else begin
            r_gnt <= 2'b00;
            if (w_load) begin
                r_gnt   <= w_win ? 2'b10 : 2'b01;
                r_lu_a  <= w_win ? i_a1  : i_a0;
                r_lu_b  <= w_win ? i_b1  : i_b0;
                r_lu_op <= w_win ? i_op1 : i_op0;
                r_win   <= w_win;
            end
        end
    end

    // Response: capture the unit's result at the end of EXEC, hold until accepted.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            o_rsp_id    <= 1'b0;
        end else if (w_capture) begin
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= i_lu_out;
            o_rsp_id    <= r_win;
        end else if (w_accept) begin
            r_rsp_valid <= 1'b0;
        end
    end

    // Fairness pointer and saturating completion count move only on acceptance.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_last <= 1'b1;
            r_cnt  <= '0;
        end else if (w_accept) begin
            r_last <= o_rsp_id;
            if (r_cnt != {CNT_W{1'b1}}) r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_gnt       = r_gnt;
    assign o_lu_a      = r_lu_a;
    assign o_lu_b      = r_lu_b;
    assign o_lu_op     = r_lu_op;
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_data  = r_rsp_data;
    assign o_op_count  = r_cnt;

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed + randomized bench for logic_unit_arbiter. A small reference model
// (fairness pointer, completion count, bitwise op table) predicts every grant
// and response. A second instance with a 2-bit counter exposes saturation.
module tb_logic_unit_arbiter;

    logic        i_clk;
    logic        i_rst_n;
    logic [1:0]  i_req;
    logic [1:0]  i_op0, i_op1;
    logic [31:0] i_a0, i_b0, i_a1, i_b1;
    logic [1:0]  o_gnt;
    logic [31:0] o_lu_a, o_lu_b;
    logic [1:0]  o_lu_op;
    logic [31:0] lu_out;
    logic        o_rsp_valid, o_rsp_id;
    logic [31:0] o_rsp_data;
    logic        i_rsp_ready;
    logic        o_busy;
    logic [15:0] o_op_count;

    logic [1:0]  s_gnt;
    logic [31:0] s_lu_a, s_lu_b, s_rsp_data;
    logic [1:0]  s_lu_op;
    logic        s_rsp_valid, s_rsp_id, s_busy;
    logic [1:0]  s_op_count;

    int n_cmp = 0;
    int n_err = 0;
    bit m_last;
    int m_cnt;

    logic_unit_arbiter #(.WIDTH(32), .CNT_W(16)) u_dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_req(i_req),
        .i_op0(i_op0), .i_a0(i_a0), .i_b0(i_b0),
        .i_op1(i_op1), .i_a1(i_a1), .i_b1(i_b1),
        .o_gnt(o_gnt), .o_lu_a(o_lu_a), .o_lu_b(o_lu_b), .o_lu_op(o_lu_op),
        .i_lu_out(lu_out), .o_rsp_valid(o_rsp_valid), .o_rsp_id(o_rsp_id),
        .o_rsp_data(o_rsp_data), .i_rsp_ready(i_rsp_ready), .o_busy(o_busy),
        .o_op_count(o_op_count)
    );

    logic_unit_arbiter #(.WIDTH(32), .CNT_W(2)) u_sat (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_req(i_req),
        .i_op0(i_op0), .i_a0(i_a0), .i_b0(i_b0),
        .i_op1(i_op1), .i_a1(i_a1), .i_b1(i_b1),
        .o_gnt(s_gnt), .o_lu_a(s_lu_a), .o_lu_b(s_lu_b), .o_lu_op(s_lu_op),
        .i_lu_out(lu_out), .o_rsp_valid(s_rsp_valid), .o_rsp_id(s_rsp_id),
        .o_rsp_data(s_rsp_data), .i_rsp_ready(i_rsp_ready), .o_busy(s_busy),
        .o_op_count(s_op_count)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    function automatic logic [31:0] ref_fn(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            2'b00:   ref_fn = a & b;
            2'b01:   ref_fn = a | b;
            2'b10:   ref_fn = a ^ b;
            default: ref_fn = ~(a | b);
        endcase
    endfunction

    // Ideal shared logic unit.
    always_comb lu_out = ref_fn(o_lu_op, o_lu_a, o_lu_b);

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int sat_exp();
        sat_exp = (m_cnt > 3) ? 3 : m_cnt;
    endfunction

    // One full operation. rq is driven into IDLE; after the grant, req becomes
    // (keep ? rq : 0) | side. delay = cycles of rsp_ready low in RESP.
    task automatic run_op(input logic [1:0] rq, input bit keep, input logic [1:0] side,
                          input int delay, input bit scr);
        bit          w;
        logic [1:0]  eop;
        logic [31:0] ea, eb, ed;
        w   = (rq == 2'b11) ? ~m_last : rq[1];
        eop = w ? i_op1 : i_op0;
        ea  = w ? i_a1  : i_a0;
        eb  = w ? i_b1  : i_b0;
        ed  = ref_fn(eop, ea, eb);
        i_req = rq;
        tick();
        chk("gnt", o_gnt, w ? 2'b10 : 2'b01);
        chk("busy", o_busy, 1);
        chk("lu_a", o_lu_a, ea);
        chk("lu_b", o_lu_b, eb);
        chk("lu_op", o_lu_op, eop);
        i_req = (keep ? rq : 2'b00) | side;
        if (scr) begin
            i_a0 = $urandom; i_b0 = $urandom; i_a1 = $urandom; i_b1 = $urandom;
            i_op0 = 2'($urandom); i_op1 = 2'($urandom);
        end
        tick();
        chk("gnt_off", o_gnt, 0);
        chk("rsp_valid", o_rsp_valid, 1);
        chk("rsp_id", o_rsp_id, w);
        chk("rsp_data", o_rsp_data, ed);
        for (int k = 0; k < delay; k++) begin
            tick();
            chk("hold_valid", o_rsp_valid, 1);
            chk("hold_id", o_rsp_id, w);
            chk("hold_data", o_rsp_data, ed);
            chk("hold_gnt", o_gnt, 0);
        end
        i_rsp_ready = 1'b1;
        tick();
        i_rsp_ready = 1'b0;
        m_last = w;
        if (m_cnt < 16'hFFFF) m_cnt++;
        chk("accept_valid", o_rsp_valid, 0);
        chk("accept_busy", o_busy, 0);
        chk("op_count", o_op_count, m_cnt);
        chk("sat_count", s_op_count, sat_exp());
    endtask

    initial begin
        i_rst_n = 1'b0; i_req = 2'b00; i_rsp_ready = 1'b0;
        i_op0 = 0; i_op1 = 0; i_a0 = 0; i_b0 = 0; i_a1 = 0; i_b1 = 0;
        m_last = 1'b1; m_cnt = 0;
        tick(); tick();
        chk("rst_gnt", o_gnt, 0);
        chk("rst_valid", o_rsp_valid, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_count", o_op_count, 0);
        chk("rst_lu_a", o_lu_a, 0);
        chk("rst_lu_op", o_lu_op, 0);
        chk("rst_data", o_rsp_data, 0);
        i_rst_n = 1'b1;
        tick();

        // Single NOR op from requester 0.
        i_op0 = 2'b11; i_a0 = 32'hFFFF0000; i_b0 = 32'h0F0F0F0F;
        run_op(2'b01, 0, 2'b00, 0, 0);
        chk("nor_data", o_rsp_data, 32'h0000F0F0);

        // Reset mid-RESP with a response pending.
        i_req = 2'b01;
        tick();
        i_req = 2'b00;
        tick();
        chk("pre_rst_valid", o_rsp_valid, 1);
        #2 i_rst_n = 1'b0;
        #1;
        chk("arst_valid", o_rsp_valid, 0);
        chk("arst_gnt", o_gnt, 0);
        chk("arst_busy", o_busy, 0);
        chk("arst_count", o_op_count, 0);
        m_last = 1'b1; m_cnt = 0;
        tick();
        i_rst_n = 1'b1;
        tick();

        // Round robin with both requesting: first tie after reset goes to 0.
        i_op0 = 2'b00; i_a0 = 32'hFFFF0000; i_b0 = 32'h0F0F0F0F;
        i_op1 = 2'b10; i_a1 = 32'hAAAAAAAA; i_b1 = 32'h55555555;
        run_op(2'b11, 1, 2'b00, 0, 0);
        chk("rr0_id", o_rsp_id, 0);
        chk("rr0_data", o_rsp_data, 32'h0F0F0000);
        run_op(2'b11, 1, 2'b00, 0, 0);
        chk("rr1_id", o_rsp_id, 1);
        chk("rr1_data", o_rsp_data, 32'hFFFFFFFF);
        run_op(2'b11, 1, 2'b00, 0, 0);
        run_op(2'b11, 1, 2'b00, 0, 0);
        i_req = 2'b00;

        // Backpressure with requester 1 waiting; it wins right after acceptance.
        run_op(2'b01, 0, 2'b10, 10, 0);
        run_op(2'b10, 0, 2'b00, 0, 0);

        // Withdrawal: requester 1 pulses req for one busy cycle only.
        i_req = 2'b01;
        tick();
        chk("wd_gnt", o_gnt, 2'b01);
        i_req = 2'b10;
        tick();
        i_req = 2'b00;
        chk("wd_gnt_exec", o_gnt, 0);
        i_rsp_ready = 1'b1;
        tick();
        i_rsp_ready = 1'b0;
        m_last = 1'b0;
        if (m_cnt < 16'hFFFF) m_cnt++;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("wd_no_gnt", o_gnt, 0);
            chk("wd_idle", o_busy, 0);
            chk("wd_count", o_op_count, m_cnt);
        end

        // Randomized operations.
        for (int n = 0; n < 24; n++) begin
            i_a0 = $urandom; i_b0 = $urandom; i_a1 = $urandom; i_b1 = $urandom;
            i_op0 = 2'($urandom); i_op1 = 2'($urandom);
            run_op(2'($urandom_range(1, 3)), 0, 2'b00, $urandom_range(0, 3), 1);
            i_req = 2'b00;
        end
        chk("sat_final", s_op_count, 2'b11);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
